// File: rtl/rst_sequencer.sv
// rst_sequencer: turns the board reset and a software reset request into
// NUM_OUT active-low reset lines. All lines assert together, stay low for
// STRETCH_CYC cycles, then release one at a time (bit 0 first) GAP_CYC apart.
module rst_sequencer #(
    parameter int NUM_OUT     = 3,
    parameter int STRETCH_CYC = 16,
    parameter int GAP_CYC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_soft_rst_req,
    output logic [NUM_OUT-1:0] o_rst_n,
    output logic               o_seq_busy,
    output logic               o_all_released,
    output logic               o_soft_rst_ack
);

    localparam int CNT_MAX = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync_n;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
    logic               busy_q, busy_d;
    logic               all_rel_q, all_rel_d;
    logic               ack_q, ack_d;
    logic               ack_pend_q, ack_pend_d;
    logic               req_q;

    logic               req_edge;
    logic               release_now;
    logic [NUM_OUT-1:0] rst_n_shift;

    // Board reset: asserts asynchronously, deasserts after SYNC_STAGES edges.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

    // Next release pattern: shift a 1 in from bit 0, so bits can only ever
    // release in index order.
    assign rst_n_shift[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < NUM_OUT; gi++) begin : g_shift
            assign rst_n_shift[gi] = rst_n_q[gi-1];
        end
    endgenerate

    // Reset value 1 so a request held high through reset is not seen as an edge.
    assign req_edge = i_soft_rst_req & ~req_q;

    // State and output registers, cleared by the synchronized reset.
    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            rst_n_q    <= '0;
            busy_q     <= 1'b1;
            all_rel_q  <= 1'b0;
            ack_q      <= 1'b0;
            ack_pend_q <= 1'b0;
            req_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_n_q    <= rst_n_d;
            busy_q     <= busy_d;
            all_rel_q  <= all_rel_d;
            ack_q      <= ack_d;
            ack_pend_q <= ack_pend_d;
            req_q      <= i_soft_rst_req;
        end
    end

    // Next-state logic: stretch, staggered release, and soft-request restart.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_n_d     = rst_n_q;
        busy_d      = busy_q;
        all_rel_d   = all_rel_q;
        ack_d       = 1'b0;
        ack_pend_d  = ack_pend_q;
        release_now = 1'b0;

        case (state_q)
            S_HOLD: begin
                if (cnt_q == STRETCH_LAST) release_now = 1'b1;
                else                       cnt_d = cnt_q + 1'b1;
            end
            S_RELEASE: begin
                if (cnt_q == GAP_LAST) release_now = 1'b1;
                else                   cnt_d = cnt_q + 1'b1;
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase

        if (release_now) begin
            cnt_d   = '0;
            rst_n_d = rst_n_shift;
            if (&rst_n_shift) begin
                state_d    = S_DONE;
                busy_d     = 1'b0;
                all_rel_d  = 1'b1;
                ack_d      = ack_pend_q;
                ack_pend_d = 1'b0;
            end else begin
                state_d = S_RELEASE;
            end
        end

        // A request edge restarts the whole sequence from this edge, in any state.
        if (req_edge) begin
            state_d    = S_HOLD;
            cnt_d      = '0;
            rst_n_d    = '0;
            busy_d     = 1'b1;
            all_rel_d  = 1'b0;
            ack_d      = 1'b0;
            ack_pend_d = 1'b1;
        end
    end

    assign o_rst_n        = rst_n_q;
    assign o_seq_busy     = busy_q;
    assign o_all_released = all_rel_q;
    assign o_soft_rst_ack = ack_q;

endmodule
